// File: rtl/pool_arbiter.sv
// Round-robin arbiter sharing one avg_pool_unit among N_REQ requesters.
// Each grant clears the unit, feeds four operands, waits out its latency, then returns the result.
module pool_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy,
    output logic                    pu_rst,
    output logic                    pu_en,
    output logic [DATA_W-1:0]       pu_din,
    input  logic [DATA_W-1:0]       pu_dout
);
    localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WaitW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic                pu_rst_q, pu_rst_d;
    logic                pu_en_q, pu_en_d;
    logic [DATA_W-1:0]   pu_din_q, pu_din_d;
    logic [2:0]          beat_q, beat_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;

    logic                sel_found;
    logic [IdxW-1:0]     sel_idx;
    logic [DATA_W-1:0]   lane;

    assign lane = req_data[grant_q*DATA_W +: DATA_W];

    // Round-robin search starting just past the last served requester.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(last_q) + k) % int'(N_REQ);
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        pu_rst_d    = 1'b0;
        pu_en_d     = 1'b0;
        pu_din_d    = pu_din_q;
        beat_d      = beat_q;
        wait_cnt_d  = wait_cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d          = StClear;
                    grant_d          = sel_idx;
                    gnt_d            = '0;
                    gnt_d[sel_idx]   = 1'b1;
                    pu_rst_d         = 1'b1;
                end
            end
            StClear: begin
                state_d = StFeed;
                beat_d  = '0;
            end
            StFeed: begin
                // Beat count of 4 is the cycle the last pu_en pulse is on the wire.
                if (beat_q == 3'd4) begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end else if (req_valid[grant_q]) begin
                    pu_en_d  = 1'b1;
                    pu_din_d = lane;
                    beat_d   = beat_q + 3'd1;
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitW'(LATENCY - 1)) begin
                    state_d              = StResp;
                    gnt_d                = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_data_d           = pu_dout;
                    last_d               = grant_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            pu_rst_q    <= 1'b1;
            pu_en_q     <= 1'b0;
            pu_din_q    <= '0;
            beat_q      <= '0;
            wait_cnt_q  <= '0;
            grant_q     <= '0;
            last_q      <= IdxW'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            pu_rst_q    <= pu_rst_d;
            pu_en_q     <= pu_en_d;
            pu_din_q    <= pu_din_d;
            beat_q      <= beat_d;
            wait_cnt_q  <= wait_cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign pu_rst    = pu_rst_q;
    assign pu_en     = pu_en_q;
    assign pu_din    = pu_din_q;

endmodule

// File: tb/tb_pool_arbiter.sv
// Bench for pool_arbiter: random and directed stimulus, a round-robin/pooling reference model
// and a scoreboard of expected responses consumed by a negedge monitor.
module tb_pool_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 5;
    localparam logic [W-1:0] POISON = 32'hDEAD_BEEF;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic           pu_rst;
    logic           pu_en;
    logic [W-1:0]   pu_din;
    logic [W-1:0]   pu_dout = POISON;

    always #5 clk = ~clk;

    pool_arbiter #(.N_REQ(N), .DATA_W(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_valid(req_valid),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .pu_rst(pu_rst), .pu_en(pu_en), .pu_din(pu_din), .pu_dout(pu_dout)
    );

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and model state shared between driver and monitor.
    exp_t         exp_q[$];
    logic [W-1:0] op_q[$];
    logic [W-1:0] dir_ops[$];
    int           gnt_log[$];
    bit           in_txn = 0;
    int           g_m = 0;
    int           grant_cyc = -100;
    int           last_m = N - 1;
    int           rsp_cnt = 0;
    int           last_lat = 0;
    int           last_rsp = 0;
    logic [W-1:0] last_rsp_data = '0;
    int           en_cnt = 0;
    bit           idle_prev = 1, resp_prev = 0, rst_prev = 1;
    logic [N-1:0] req_prev = '0;
    longint       pu_sum = 0;
    int           pu_cnt = 0, pu_done_cyc = 0;
    bit           pu_done = 0;
    int           beats = 0, stall_cnt = 0, stall_at = -1, stall_len = 0, valid_pct = 100;
    longint       acc_sum = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got false want true (cycle %0d)", name, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Requester side: present operands, predict which beat the arbiter takes, queue the result.
    task automatic drive_cycle();
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        exp_t           e;
        bit             feed;
        for (int i = 0; i < N; i++) begin
            v[i]         = ($urandom_range(99) < valid_pct);
            d[i*W +: W]  = $urandom;
        end
        if (in_txn && cyc == grant_cyc + 1) begin
            beats     = 0;
            stall_cnt = 0;
            acc_sum   = 0;
        end
        feed = in_txn && cyc > grant_cyc && beats < 4;
        if (feed) begin
            if (dir_ops.size() != 0) d[g_m*W +: W] = dir_ops[0];
            if (beats == stall_at && stall_cnt < stall_len) begin
                v[g_m] = 1'b0;
                stall_cnt++;
            end
            if (v[g_m]) begin
                op_q.push_back(d[g_m*W +: W]);
                acc_sum += longint'($signed(d[g_m*W +: W]));
                if (dir_ops.size() != 0) dir_ops.delete(0);
                beats++;
                if (beats == 4) begin
                    e.id   = g_m;
                    e.data = W'(acc_sum >>> 2);
                    e.due  = cyc + 2 + LAT;
                    exp_q.push_back(e);
                end
            end
        end
        req_valid = v;
        req_data  = d;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    end

    // Monitor: pooling-unit model, arbitration model and scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   pick;
        bit   idle_now, resp_now;
        idle_now = 0;
        resp_now = 0;
        if (rst_prev) begin
            check("rst_gnt", gnt, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_busy", busy, 0);
            check("rst_pu_rst", pu_rst, 1);
            check("rst_pu_en", pu_en, 0);
            check("rst_pu_din", pu_din, 0);
            in_txn   = 0;
            last_m   = N - 1;
            exp_q.delete();
            op_q.delete();
            idle_now = 1;
        end else begin
            check("gnt_onehot0", $onehot0(gnt), 1);
            check("rsp_onehot0", $onehot0(rsp_valid), 1);
            if (pu_en) begin
                check_true("pu_en_in_feed", in_txn && cyc > grant_cyc && !pu_rst && rsp_valid == 0);
                check_true("pu_din_queued", op_q.size() != 0);
                if (op_q.size() != 0) check("pu_din", pu_din, op_q.pop_front());
                en_cnt++;
            end
            if (idle_prev && req_prev != 0) begin
                pick = rr_pick(req_prev, last_m);
                check("gnt_pick", gnt, 1 << pick);
                check("clear_pu_rst", pu_rst, 1);
                check("clear_busy", busy, 1);
                in_txn    = 1;
                g_m       = pick;
                grant_cyc = cyc;
                en_cnt    = 0;
                gnt_log.push_back(int'(gnt));
            end else if (idle_prev || resp_prev) begin
                check("idle_gnt", gnt, 0);
                check("idle_rsp_valid", rsp_valid, 0);
                check("idle_busy", busy, 0);
                idle_now = 1;
            end else if (in_txn) begin
                if (rsp_valid != 0) begin
                    resp_now = 1;
                    check("resp_gnt", gnt, 0);
                    check("resp_pu_en_count", en_cnt, 4);
                    check_true("resp_expected", exp_q.size() != 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_valid", rsp_valid, 1 << e.id);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_cycle", cyc, e.due);
                    end
                    last_m        = g_m;
                    in_txn        = 0;
                    rsp_cnt++;
                    last_lat      = cyc - grant_cyc;
                    last_rsp      = int'(rsp_valid);
                    last_rsp_data = rsp_data;
                end else begin
                    check("hold_gnt", gnt, 1 << g_m);
                    check("hold_busy", busy, 1);
                end
            end
        end
        // Pooling unit: averages four enabled operands, result visible LAT cycles after the last.
        if (pu_rst) begin
            pu_sum  = 0;
            pu_cnt  = 0;
            pu_done = 0;
        end else if (pu_en) begin
            pu_sum += longint'($signed(pu_din));
            pu_cnt++;
            if (pu_cnt == 4) begin
                pu_done     = 1;
                pu_done_cyc = cyc;
            end
        end
        pu_dout   = (pu_done && cyc >= pu_done_cyc + LAT) ? W'(pu_sum >>> 2) : POISON;
        idle_prev = idle_now;
        resp_prev = resp_now;
        req_prev  = req;
        rst_prev  = rst;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check_true(name, rsp_cnt >= target);
    endtask

    task automatic wait_gnt(input int budget, input string name);
        int n = 0;
        while (gnt_log.size() == 0 && n < budget) begin
            step(1);
            n++;
        end
        check_true(name, gnt_log.size() != 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || in_txn) && n < budget) begin
            step(1);
            n++;
        end
        check_true(name, !busy && !in_txn);
    endtask

    initial begin
        int rr_exp[5] = '{1, 2, 4, 8, 1};
        int base, rsp_before;
        rst = 1'b1;
        req = '0;
        step(3);
        rst = 1'b0;
        step(2);

        // Single request with known operands.
        dir_ops = '{32'd10, 32'd20, 32'd30, 32'd40};
        req     = 4'b0001;
        wait_rsp(rsp_cnt + 1, 60, "single_wait");
        req = '0;
        check("single_latency", last_lat, 1 + 4 + LAT + 1);
        check("single_id", last_rsp, 1);
        check("single_data", last_rsp_data, 25);
        wait_idle(40, "single_idle");

        // Round robin from a fresh reset with every requester held.
        do_reset(2);
        gnt_log.delete();
        base = rsp_cnt;
        req  = 4'b1111;
        wait_rsp(base + 5, 100, "rr_wait");
        req = '0;
        wait_idle(40, "rr_idle");
        for (int i = 0; i < 5; i++) if (i < gnt_log.size()) check("rr_order", gnt_log[i], rr_exp[i]);
        check("rr_one_rsp_per_gnt", rsp_cnt - base, gnt_log.size());

        // Stall of three cycles between beats 2 and 3.
        dir_ops   = '{32'd10, 32'd20, 32'd30, 32'd40};
        stall_at  = 2;
        stall_len = 3;
        req       = 4'b0001;
        wait_rsp(rsp_cnt + 1, 60, "stall_wait");
        req = '0;
        check("stall_latency", last_lat, 1 + 4 + LAT + 1 + 3);
        check("stall_data", last_rsp_data, 25);
        stall_at = -1;
        wait_idle(40, "stall_idle");

        // Request withdrawn after grant still completes.
        gnt_log.delete();
        req = 4'b0100;
        wait_gnt(20, "withdraw_gnt");
        req = '0;
        wait_rsp(rsp_cnt + 1, 60, "withdraw_wait");
        check("withdraw_id", last_rsp, 4'b0100);
        wait_idle(40, "withdraw_idle");

        // Reset while feeding aborts without a response; requester 0 wins afterwards.
        gnt_log.delete();
        req = 4'b0010;
        wait_gnt(20, "abort_gnt");
        step(2);
        rsp_before = rsp_cnt;
        gnt_log.delete();
        req = 4'b0011;
        do_reset(2);
        check("abort_no_rsp", rsp_cnt, rsp_before);
        wait_gnt(20, "abort_regnt");
        if (gnt_log.size() != 0) check("abort_first_gnt", gnt_log[0], 1);
        wait_rsp(rsp_cnt + 1, 60, "abort_rsp");
        req = '0;
        wait_idle(40, "abort_idle");

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            req       = N'($urandom_range(0, 15));
            valid_pct = $urandom_range(30, 100);
            step($urandom_range(1, 15));
        end
        req       = '0;
        valid_pct = 100;
        wait_idle(200, "random_idle");
        step(2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
